// File: rtl/dbus_responder_if.sv
// Load/store request/response bundle between the memory stage (master) and
// its data-bus responder (slave). resp_err exists only with DBUS_MISALIGN_ERR_EN.
interface dbus_responder_if #(
    parameter int ADDR_W = 64
);
    // Handshake: the master raises req_valid and holds every req_* field stable
    // until it sees resp_data_ok (then drops req_valid the next cycle) or it
    // aborts by dropping req_valid early; resp_addr_ok/resp_data_ok are
    // single-cycle pulses and resp_data is meaningful only while resp_data_ok=1.
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_size;
    logic [7:0]        req_strobe;
    logic [63:0]       req_data;
    logic              resp_addr_ok;
    logic              resp_data_ok;
    logic [63:0]       resp_data;
`ifdef DBUS_MISALIGN_ERR_EN
    logic              resp_err;

    modport master (
        output req_valid, req_addr, req_size, req_strobe, req_data,
        input  resp_addr_ok, resp_data_ok, resp_data, resp_err
    );
    modport slave (
        input  req_valid, req_addr, req_size, req_strobe, req_data,
        output resp_addr_ok, resp_data_ok, resp_data, resp_err
    );
`else
    modport master (
        output req_valid, req_addr, req_size, req_strobe, req_data,
        input  resp_addr_ok, resp_data_ok, resp_data
    );
    modport slave (
        input  req_valid, req_addr, req_size, req_strobe, req_data,
        output resp_addr_ok, resp_data_ok, resp_data
    );
`endif
endinterface

// File: rtl/dbus_responder.sv
// Data-bus responder: one-at-a-time 64-bit synchronous RAM with programmable
// response latency. Optional misalignment error response: DBUS_MISALIGN_ERR_EN.
module dbus_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    dbus_responder_if.slave   bus,
    output logic [1:0]        dbgState
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Two-state storage so the RAM reads as zero from time 0 without a reset.
    bit   [63:0]      mem [DEPTH];

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] idxQ;
    logic [7:0]       strobeQ;
    logic [63:0]      dataQ;
    logic             errQ;
    logic [IDX_W-1:0] reqIdx;
    logic             reqErr;

    assign reqIdx   = bus.req_addr[IDX_W+2:3];
    assign dbgState = state;

`ifdef DBUS_MISALIGN_ERR_EN
    logic [7:0] alignMask;
    assign alignMask = (8'd1 << bus.req_size) - 8'd1;
    assign reqErr    = |(bus.req_addr[7:0] & alignMask);
`else
    assign reqErr    = 1'b0;
`endif

    // Address bits outside the word index (and size, when unchecked) are ignored.
    logic unusedBits;
    assign unusedBits = ^{bus.req_addr, bus.req_size};

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= 4'd0;
            idxQ             <= '0;
            strobeQ          <= 8'd0;
            dataQ            <= 64'd0;
            errQ             <= 1'b0;
            bus.resp_addr_ok <= 1'b0;
            bus.resp_data_ok <= 1'b0;
            bus.resp_data    <= 64'd0;
`ifdef DBUS_MISALIGN_ERR_EN
            bus.resp_err     <= 1'b0;
`endif
        end else begin
            bus.resp_addr_ok <= 1'b0;
            bus.resp_data_ok <= 1'b0;
            bus.resp_data    <= 64'd0;
`ifdef DBUS_MISALIGN_ERR_EN
            bus.resp_err     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        idxQ    <= reqIdx;
                        strobeQ <= bus.req_strobe;
                        dataQ   <= bus.req_data;
                        errQ    <= reqErr;
                        cnt     <= 4'(LATENCY);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (!bus.req_valid) begin
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        state            <= RESP;
                        bus.resp_addr_ok <= 1'b1;
                        bus.resp_data_ok <= 1'b1;
                        // Pre-write word: the write lands when RESP is left.
                        bus.resp_data    <= errQ ? 64'd0 : mem[idxQ];
`ifdef DBUS_MISALIGN_ERR_EN
                        bus.resp_err     <= errQ;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == RESP && !errQ) begin
            for (int i = 0; i < 8; i++) begin
                if (strobeQ[i]) mem[idxQ][8*i +: 8] <= dataQ[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dbus_responder.sv
// Self-checking bench for dbus_responder: directed cases plus a random mix,
// with a reference RAM model feeding an expected-response queue.
module tb_dbus_responder;
    localparam int LATENCY = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbgState;
    int         checks = 0;
    int         failures = 0;

    bit   [63:0] model [1024];
    logic [63:0] expQ[$];
    logic        expErrQ[$];

    dbus_responder_if #(.ADDR_W(64)) bus ();

    dbus_responder #(.DEPTH(1024), .LATENCY(LATENCY), .ADDR_W(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .dbgState (dbgState)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every data_ok pops one expected response.
    always @(negedge clk) begin
        if (!reset && bus.resp_data_ok) begin
            if (expQ.size() == 0) begin
                checkVal("unexpected_resp", 64'd1, 64'd0);
            end else begin
                checkVal("rdata", bus.resp_data, expQ.pop_front());
                checkVal("addr_ok", {63'd0, bus.resp_addr_ok}, 64'd1);
`ifdef DBUS_MISALIGN_ERR_EN
                checkVal("resp_err", {63'd0, bus.resp_err}, {63'd0, expErrQ.pop_front()});
`else
                void'(expErrQ.pop_front());
`endif
            end
        end
    end

    task automatic idleBus();
        bus.req_valid  = 1'b0;
        bus.req_addr   = 64'd0;
        bus.req_size   = 3'd3;
        bus.req_strobe = 8'd0;
        bus.req_data   = 64'd0;
    endtask

    task automatic driveReq(input logic [63:0] addr, input logic [2:0] size,
                            input logic [7:0] strobe, input logic [63:0] data);
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.req_size   = size;
        bus.req_strobe = strobe;
        bus.req_data   = data;
    endtask

    task automatic doTxn(input logic [63:0] addr, input logic [2:0] size,
                         input logic [7:0] strobe, input logic [63:0] data);
        logic [9:0] idx;
        logic       err;
        logic [7:0] mask;
        int         n;
        idx  = addr[12:3];
        mask = (8'd1 << size) - 8'd1;
`ifdef DBUS_MISALIGN_ERR_EN
        err  = |(addr[7:0] & mask);
`else
        err  = 1'b0;
`endif
        expQ.push_back(err ? 64'd0 : model[idx]);
        expErrQ.push_back(err);
        if (!err) begin
            for (int i = 0; i < 8; i++)
                if (strobe[i]) model[idx][8*i +: 8] = data[8*i +: 8];
        end
        driveReq(addr, size, strobe, data);
        n = 0;
        @(negedge clk);
        while (!bus.resp_data_ok && n < 40) begin
            n++;
            @(negedge clk);
        end
        checkVal("latency", 64'(n), 64'(LATENCY + 2));
        @(posedge clk); #1;
        idleBus();
        @(negedge clk);
        checkVal("data_ok_pulse", {63'd0, bus.resp_data_ok}, 64'd0);
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    initial begin
        int seen;
        idleBus();
        waitCycles(3);
        @(negedge clk);
        checkVal("rst_addr_ok", {63'd0, bus.resp_addr_ok}, 64'd0);
        checkVal("rst_data_ok", {63'd0, bus.resp_data_ok}, 64'd0);
        checkVal("rst_data", bus.resp_data, 64'd0);
        checkVal("rst_state", {62'd0, dbgState}, 64'd0);
        reset = 1'b0;

        // Cold read, then write/read-back, then partial strobe merge.
        doTxn(64'h80, 3'd3, 8'h00, 64'd0);
        doTxn(64'h10, 3'd3, 8'hFF, 64'h1122334455667788);
        doTxn(64'h10, 3'd3, 8'h00, 64'd0);
        doTxn(64'h10, 3'd3, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
        doTxn(64'h10, 3'd3, 8'h00, 64'd0);
        checkVal("merge_model", model[2], 64'h11223344BBBBBBBB);

        // Abort during WAIT: no response, no write.
        driveReq(64'h20, 3'd3, 8'hFF, 64'hDEADBEEF_CAFEF00D);
        @(negedge clk);
        @(negedge clk);
        checkVal("state_wait", {62'd0, dbgState}, 64'd1);
        @(posedge clk); #1;
        idleBus();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.resp_data_ok) seen++;
        end
        checkVal("abort_no_resp", 64'(seen), 64'd0);
        doTxn(64'h20, 3'd3, 8'h00, 64'd0);

        // Reset while a write to 0x30 sits in WAIT.
        driveReq(64'h30, 3'd3, 8'hFF, 64'h0123456789ABCDEF);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        idleBus();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkVal("rst_mid_data_ok", {63'd0, bus.resp_data_ok}, 64'd0);
        checkVal("rst_mid_data", bus.resp_data, 64'd0);
        checkVal("rst_mid_state", {62'd0, dbgState}, 64'd0);
        doTxn(64'h30, 3'd3, 8'h00, 64'd0);

        // Aliasing: high address bits and addr[2:0] ignored.
        doTxn(64'hFFFF_0000_0000_2010 | 64'h5, 3'd3, 8'h00, 64'd0);

`ifdef DBUS_MISALIGN_ERR_EN
        doTxn(64'h42, 3'd2, 8'h3C, 64'h0000_5566_7788_0000);
        doTxn(64'h40, 3'd3, 8'h00, 64'd0);
        doTxn(64'h44, 3'd2, 8'hF0, 64'h99AA_BBCC_0000_0000);
        doTxn(64'h40, 3'd3, 8'h00, 64'd0);
`endif

        // Random mix over a few words so reads hit earlier writes.
        for (int k = 0; k < 24; k++) begin
            logic [63:0] a;
            logic [63:0] d;
            logic [7:0]  s;
            a = 64'($urandom_range(0, 7)) << 3;
            a = a | 64'($urandom_range(0, 7));
            s = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            d = {$urandom, $urandom};
            doTxn(a, 3'($urandom_range(0, 3)), s, d);
        end

        seen = 0;
        while (expQ.size() != 0 && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        checkVal("queue_drained", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
